// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
//
// Main instruction decoder for the ID stage of the 5-stage MIPS pipeline.
// Turns opcode/funct plus the ID-stage register-equality result into the
// datapath controls for PC selection, IF squashing, ALU operation, data memory
// and writeback. Decode is purely combinational. The only state is a sticky
// flag that remembers whether an unsupported instruction was ever decoded.
//
// Ports
//   i_clock          in   1  system clock
//   i_reset          in   1  synchronous, active-high; clears the sticky flag
//   i_opcode         in   6  instr[31:26]
//   i_funct          in   6  instr[5:0]
//   i_cmp_rs_rt      in   1  1 when Rs == Rt (ID-stage comparator)
//   o_if_flush       out  1  squash the instruction in IF
//   o_sign_ext       out  1  1 = sign-extend imm16, 0 = zero-extend
//   o_pc_src         out  2  00 PC+4, 01 branch target, 10 jump target, 11 Rs
//   o_no_dest        out  1  no GPR destination (hazard/forwarding ignore)
//   o_alu_ctrl       out  3  000 ADD, 001 SUB, 010 OR, 011 SLT, 100 SLL,
//                            101 MUL, 110 DIV/HI unit, 111 LUI (B<<16)
//   o_alu_src        out  1  1 = immediate operand B, 0 = Rt
//   o_reg_dst        out  1  1 = rd, 0 = rt
//   o_mem_write      out  1  data-memory write
//   o_mem_read       out  1  data-memory read
//   o_reg_write      out  1  GPR writeback
//   o_mem_to_reg     out  1  1 = writeback from memory
//   o_branch         out  1  conditional-branch instruction present
//   o_illegal_instr  out  1  combinational: unsupported opcode/funct
//   o_illegal_seen   out  1  registered sticky copy of o_illegal_instr
// -----------------------------------------------------------------------------
module control_unit (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    input  logic       i_cmp_rs_rt,
    output logic       o_if_flush,
    output logic       o_sign_ext,
    output logic [1:0] o_pc_src,
    output logic       o_no_dest,
    output logic [2:0] o_alu_ctrl,
    output logic       o_alu_src,
    output logic       o_reg_dst,
    output logic       o_mem_write,
    output logic       o_mem_read,
    output logic       o_reg_write,
    output logic       o_mem_to_reg,
    output logic       o_branch,
    output logic       o_illegal_instr,
    output logic       o_illegal_seen
);

    // Opcodes
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_R2   = 6'b011100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    // R-type functs
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_DIV  = 6'b011010;
    localparam logic [5:0] FN_MFHI = 6'b010000;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_JR   = 6'b001000;

    // R2 funct
    localparam logic [5:0] FN_MUL  = 6'b000010;

    // ALU encodings
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_SLT = 3'b011;
    localparam logic [2:0] ALU_SLL = 3'b100;
    localparam logic [2:0] ALU_MUL = 3'b101;
    localparam logic [2:0] ALU_HI  = 3'b110;
    localparam logic [2:0] ALU_LUI = 3'b111;

    // PC source encodings
    localparam logic [1:0] PC_SEQ  = 2'b00;
    localparam logic [1:0] PC_BR   = 2'b01;
    localparam logic [1:0] PC_JMP  = 2'b10;
    localparam logic [1:0] PC_RS   = 2'b11;

    logic       w_if_flush;
    logic       w_sign_ext;
    logic [1:0] w_pc_src;
    logic       w_no_dest;
    logic [2:0] w_alu_ctrl;
    logic       w_alu_src;
    logic       w_reg_dst;
    logic       w_mem_write;
    logic       w_mem_read;
    logic       w_reg_write;
    logic       w_mem_to_reg;
    logic       w_branch;
    logic       w_illegal;
    logic       w_br_taken;
    logic       r_illegal_seen;

    // Instruction decode: start from the all-zero NOP set, then raise only the
    // controls each instruction needs. Anything unrecognised falls to the
    // illegal set, which has no architectural side effects.
    always_comb begin
        w_if_flush   = 1'b0;
        w_sign_ext   = 1'b0;
        w_pc_src     = PC_SEQ;
        w_no_dest    = 1'b0;
        w_alu_ctrl   = ALU_ADD;
        w_alu_src    = 1'b0;
        w_reg_dst    = 1'b0;
        w_mem_write  = 1'b0;
        w_mem_read   = 1'b0;
        w_reg_write  = 1'b0;
        w_mem_to_reg = 1'b0;
        w_branch     = 1'b0;
        w_illegal    = 1'b0;
        w_br_taken   = 1'b0;

        case (i_opcode)
            OP_R: begin
                case (i_funct)
                    FN_ADD: begin
                        w_reg_dst   = 1'b1;
                        w_reg_write = 1'b1;
                        w_alu_ctrl  = ALU_ADD;
                    end
                    FN_SUB: begin
                        w_reg_dst   = 1'b1;
                        w_reg_write = 1'b1;
                        w_alu_ctrl  = ALU_SUB;
                    end
                    FN_SLT: begin
                        w_reg_dst   = 1'b1;
                        w_reg_write = 1'b1;
                        w_alu_ctrl  = ALU_SLT;
                    end
                    FN_SLL: begin
                        // Shift amount comes from the shamt field, so operand B
                        // stays on Rt.
                        w_reg_dst   = 1'b1;
                        w_reg_write = 1'b1;
                        w_alu_ctrl  = ALU_SLL;
                    end
                    FN_DIV: begin
                        // Divider updates HI/LO internally; no GPR result.
                        w_alu_ctrl  = ALU_HI;
                        w_no_dest   = 1'b1;
                    end
                    FN_MFHI: begin
                        // Same unit as div; RegWrite tells it to return HI.
                        w_alu_ctrl  = ALU_HI;
                        w_reg_dst   = 1'b1;
                        w_reg_write = 1'b1;
                    end
                    FN_JR: begin
                        w_pc_src    = PC_RS;
                        w_if_flush  = 1'b1;
                        w_no_dest   = 1'b1;
                    end
                    default: begin
                        w_no_dest   = 1'b1;
                        w_illegal   = 1'b1;
                    end
                endcase
            end
            OP_R2: begin
                if (i_funct == FN_MUL) begin
                    w_reg_dst   = 1'b1;
                    w_reg_write = 1'b1;
                    w_alu_ctrl  = ALU_MUL;
                end else begin
                    w_no_dest   = 1'b1;
                    w_illegal   = 1'b1;
                end
            end
            OP_ADDI: begin
                w_alu_src   = 1'b1;
                w_sign_ext  = 1'b1;
                w_reg_write = 1'b1;
                w_alu_ctrl  = ALU_ADD;
            end
            OP_ORI: begin
                // Logical immediate: zero-extended.
                w_alu_src   = 1'b1;
                w_reg_write = 1'b1;
                w_alu_ctrl  = ALU_OR;
            end
            OP_LUI: begin
                w_alu_src   = 1'b1;
                w_reg_write = 1'b1;
                w_alu_ctrl  = ALU_LUI;
            end
            OP_LW: begin
                w_alu_src    = 1'b1;
                w_sign_ext   = 1'b1;
                w_mem_read   = 1'b1;
                w_mem_to_reg = 1'b1;
                w_reg_write  = 1'b1;
                w_alu_ctrl   = ALU_ADD;
            end
            OP_SW: begin
                w_alu_src   = 1'b1;
                w_sign_ext  = 1'b1;
                w_mem_write = 1'b1;
                w_no_dest   = 1'b1;
                w_alu_ctrl  = ALU_ADD;
            end
            OP_BEQ, OP_BNE: begin
                // Branches resolve in ID from the register comparator; bne is
                // taken on inequality, beq on equality.
                w_branch   = 1'b1;
                w_sign_ext = 1'b1;
                w_no_dest  = 1'b1;
                w_alu_ctrl = ALU_SUB;
                if (i_opcode == OP_BEQ) begin
                    w_br_taken = i_cmp_rs_rt;
                end else begin
                    w_br_taken = ~i_cmp_rs_rt;
                end
                if (w_br_taken) begin
                    w_pc_src   = PC_BR;
                    w_if_flush = 1'b1;
                end else begin
                    w_pc_src   = PC_SEQ;
                    w_if_flush = 1'b0;
                end
            end
            OP_J: begin
                w_pc_src   = PC_JMP;
                w_if_flush = 1'b1;
                w_no_dest  = 1'b1;
            end
            OP_JAL: begin
                // Datapath forces the link value (PC+8) and destination $31.
                w_pc_src    = PC_JMP;
                w_if_flush  = 1'b1;
                w_reg_write = 1'b1;
            end
            default: begin
                w_no_dest = 1'b1;
                w_illegal = 1'b1;
            end
        endcase
    end

    // Sticky illegal-instruction flag; reset wins over a concurrent illegal.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_illegal_seen <= 1'b0;
        end else begin
            r_illegal_seen <= r_illegal_seen | w_illegal;
        end
    end

    assign o_if_flush      = w_if_flush;
    assign o_sign_ext      = w_sign_ext;
    assign o_pc_src        = w_pc_src;
    assign o_no_dest       = w_no_dest;
    assign o_alu_ctrl      = w_alu_ctrl;
    assign o_alu_src       = w_alu_src;
    assign o_reg_dst       = w_reg_dst;
    assign o_mem_write     = w_mem_write;
    assign o_mem_read      = w_mem_read;
    assign o_reg_write     = w_reg_write;
    assign o_mem_to_reg    = w_mem_to_reg;
    assign o_branch        = w_branch;
    assign o_illegal_instr = w_illegal;
    assign o_illegal_seen  = r_illegal_seen;

endmodule

// File: tb/tb_control_unit.sv
// -----------------------------------------------------------------------------
// tb_control_unit
//
// Directed-vector bench for control_unit. Each decode vector is compared as a
// 16-bit bundle {if_flush, sign_ext, pc_src, no_dest, alu_ctrl, alu_src,
// reg_dst, mem_write, mem_read, reg_write, mem_to_reg, branch, illegal_instr}
// against a hand-written expected bundle; the sticky flag is checked across
// clock edges.
// -----------------------------------------------------------------------------
module tb_control_unit;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       cmp;
    logic       if_flush;
    logic       sign_ext;
    logic [1:0] pc_src;
    logic       no_dest;
    logic [2:0] alu_ctrl;
    logic       alu_src;
    logic       reg_dst;
    logic       mem_write;
    logic       mem_read;
    logic       reg_write;
    logic       mem_to_reg;
    logic       branch;
    logic       illegal_instr;
    logic       illegal_seen;

    int n_vec;
    int n_err;

    control_unit dut (
        .i_clock         (clk),
        .i_reset         (rst),
        .i_opcode        (opcode),
        .i_funct         (funct),
        .i_cmp_rs_rt     (cmp),
        .o_if_flush      (if_flush),
        .o_sign_ext      (sign_ext),
        .o_pc_src        (pc_src),
        .o_no_dest       (no_dest),
        .o_alu_ctrl      (alu_ctrl),
        .o_alu_src       (alu_src),
        .o_reg_dst       (reg_dst),
        .o_mem_write     (mem_write),
        .o_mem_read      (mem_read),
        .o_reg_write     (reg_write),
        .o_mem_to_reg    (mem_to_reg),
        .o_branch        (branch),
        .o_illegal_instr (illegal_instr),
        .o_illegal_seen  (illegal_seen)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: count and report
    task automatic check_eq(input string tag, input logic [15:0] obs,
                            input logic [15:0] exp);
        n_vec = n_vec + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Build an expected bundle field by field
    function automatic logic [15:0] e(
        input logic fl, input logic se, input logic [1:0] pc, input logic nd,
        input logic [2:0] alu, input logic as, input logic rd, input logic mw,
        input logic mr, input logic rw, input logic m2r, input logic br,
        input logic il);
        return {fl, se, pc, nd, alu, as, rd, mw, mr, rw, m2r, br, il};
    endfunction

    function automatic logic [15:0] obs_bundle();
        return {if_flush, sign_ext, pc_src, no_dest, alu_ctrl, alu_src,
                reg_dst, mem_write, mem_read, reg_write, mem_to_reg, branch,
                illegal_instr};
    endfunction

    // Drive an instruction on the falling edge and let decode settle
    task automatic apply(input logic [5:0] op, input logic [5:0] fn,
                         input logic c);
        @(negedge clk);
        opcode = op;
        funct  = fn;
        cmp    = c;
        #1;
    endtask

    task automatic vec(input string tag, input logic [5:0] op,
                       input logic [5:0] fn, input logic c,
                       input logic [15:0] exp);
        apply(op, fn, c);
        check_eq(tag, obs_bundle(), exp);
    endtask

    // Wait one rising edge and sample just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] NOP_ILL;

    initial begin
        n_vec   = 0;
        n_err   = 0;
        rst     = 1'b1;
        opcode  = 6'b001000;
        funct   = 6'b000000;
        cmp     = 1'b0;
        NOP_ILL = e(1'b0,1'b0,2'b00,1'b1,3'b000,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1);

        // Reset state
        tick();
        tick();
        check_eq("reset_seen", {15'd0, illegal_seen}, 16'd0);
        @(negedge clk);
        rst = 1'b0;

        // R-type ALU ops and mul
        vec("add",  6'b000000, 6'b100000, 1'b0, e(1'b0,1'b0,2'b00,1'b0,3'b000,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0));
        vec("add_cmp1", 6'b000000, 6'b100000, 1'b1, e(1'b0,1'b0,2'b00,1'b0,3'b000,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0));
        vec("sub",  6'b000000, 6'b100010, 1'b0, e(1'b0,1'b0,2'b00,1'b0,3'b001,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0));
        vec("slt",  6'b000000, 6'b101010, 1'b0, e(1'b0,1'b0,2'b00,1'b0,3'b011,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0));
        vec("sll",  6'b000000, 6'b000000, 1'b0, e(1'b0,1'b0,2'b00,1'b0,3'b100,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0));
        vec("mul",  6'b011100, 6'b000010, 1'b0, e(1'b0,1'b0,2'b00,1'b0,3'b101,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0));

        // div / mfhi / jr
        vec("div",  6'b000000, 6'b011010, 1'b0, e(1'b0,1'b0,2'b00,1'b1,3'b110,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0));
        vec("mfhi", 6'b000000, 6'b010000, 1'b0, e(1'b0,1'b0,2'b00,1'b0,3'b110,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0));
        vec("jr",   6'b000000, 6'b001000, 1'b1, e(1'b1,1'b0,2'b11,1'b1,3'b000,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0));

        // Immediate and memory ops
        vec("addi", 6'b001000, 6'b111111, 1'b0, e(1'b0,1'b1,2'b00,1'b0,3'b000,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0));
        vec("ori",  6'b001101, 6'b000000, 1'b0, e(1'b0,1'b0,2'b00,1'b0,3'b010,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0));
        vec("lui",  6'b001111, 6'b000000, 1'b0, e(1'b0,1'b0,2'b00,1'b0,3'b111,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0));
        vec("lw",   6'b100011, 6'b000000, 1'b0, e(1'b0,1'b1,2'b00,1'b0,3'b000,1'b1,1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,1'b0));
        vec("sw",   6'b101011, 6'b000000, 1'b0, e(1'b0,1'b1,2'b00,1'b1,3'b000,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0));

        // Branch matrix
        vec("beq_c0", 6'b000100, 6'b000000, 1'b0, e(1'b0,1'b1,2'b00,1'b1,3'b001,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0));
        vec("beq_c1", 6'b000100, 6'b000000, 1'b1, e(1'b1,1'b1,2'b01,1'b1,3'b001,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0));
        vec("bne_c0", 6'b000101, 6'b000000, 1'b0, e(1'b1,1'b1,2'b01,1'b1,3'b001,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0));
        vec("bne_c1", 6'b000101, 6'b000000, 1'b1, e(1'b0,1'b1,2'b00,1'b1,3'b001,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0));

        // Jumps
        vec("j",    6'b000010, 6'b000000, 1'b0, e(1'b1,1'b0,2'b10,1'b1,3'b000,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0));
        vec("jal",  6'b000011, 6'b000000, 1'b0, e(1'b1,1'b0,2'b10,1'b0,3'b000,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0));

        // Only legal instructions so far: flag must still be clear
        check_eq("seen_after_legal", {15'd0, illegal_seen}, 16'd0);

        // Illegal encodings
        vec("ill_op", 6'b111111, 6'b000000, 1'b0, NOP_ILL);
        check_eq("seen_before_edge", {15'd0, illegal_seen}, 16'd0);
        tick();
        check_eq("seen_rise", {15'd0, illegal_seen}, 16'd1);
        vec("ill_fn", 6'b000000, 6'b111111, 1'b1, NOP_ILL);
        vec("ill_r2", 6'b011100, 6'b000000, 1'b0, NOP_ILL);
        vec("ill_op1", 6'b000001, 6'b100000, 1'b1, NOP_ILL);

        // Sticky across a following valid instruction
        vec("add_after_ill", 6'b000000, 6'b100000, 1'b0, e(1'b0,1'b0,2'b00,1'b0,3'b000,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0));
        tick();
        check_eq("seen_hold", {15'd0, illegal_seen}, 16'd1);

        // Reset for one edge clears it
        @(negedge clk);
        rst = 1'b1;
        tick();
        check_eq("seen_reset", {15'd0, illegal_seen}, 16'd0);

        // Reset with an illegal instruction present: reset wins, decode ungated
        apply(6'b000000, 6'b111111, 1'b0);
        check_eq("ill_in_reset", obs_bundle(), NOP_ILL);
        tick();
        check_eq("seen_reset_prio", {15'd0, illegal_seen}, 16'd0);

        // Release reset with the illegal still present: flag sets again
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_eq("seen_rearm", {15'd0, illegal_seen}, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Main instruction decoder for the 5-stage MIPS pipeline; sits in the ID stage.
- Decodes Opcode/Funct plus the ID-stage register-equality result (Cmp_RsRt) into datapath controls: PC select, IF flush, ALU op, memory and writeback controls.
- Decode is purely combinational. The only state is a sticky illegal-instruction flag.

Parameters:
- None. Opcode, funct and ALU encodings are fixed constants from the shared opcode/datapath parameter includes.

Ports:
- Clock  in  1  system clock
- Reset  in  1  synchronous, active-high; clears the sticky flag
- Opcode  in  6  instr[31:26]
- Funct  in  6  instr[5:0]
- Cmp_RsRt  in  1  1 when Rs==Rt (ID-stage comparator)
- IF_Flush  out  1  squash the instruction in IF
- SignExt  out  1  1 = sign-extend imm16, 0 = zero-extend
- PCSrc  out  2  00 PC+4, 01 branch target, 10 jump target, 11 Rs (jr)
- NoDest  out  1  no GPR destination (hazard/forwarding ignore)
- ALUCtrl  out  3  000 ADD, 001 SUB, 010 OR, 011 SLT, 100 SLL, 101 MUL, 110 DIV/HI unit, 111 LUI (B<<16)
- ALUSrc  out  1  1 = immediate operand B, 0 = Rt
- RegDst  out  1  1 = rd, 0 = rt
- MemWrite  out  1  data-memory write
- MemRead  out  1  data-memory read
- RegWrite  out  1  GPR writeback
- MemtoReg  out  1  1 = writeback from memory
- Branch  out  1  conditional-branch instruction present
- IllegalInstr  out  1  combinational: unsupported opcode/funct
- IllegalSeen  out  1  registered sticky copy of IllegalInstr

Behaviour:
- Encodings:
  - Opcodes: R=000000, R2=011100, Addi=001000, Ori=001101, Lui=001111, Beq=000100, Bne=000101, J=000010, Jal=000011, Lw=100011, Sw=101011.
  - R functs: Add=100000, Sub=100010, Sll=000000, Div=011010, Mfhi=010000, Slt=101010, Jr=001000.
  - R2 funct: Mul=000010.
- Default for every output is 0 ("NOP" set). Each instruction below lists only the signals that differ from 0.
- add/sub/slt/sll: RegDst=1, RegWrite=1, ALUCtrl=000/001/011/100. Sll takes shamt from the instruction, ALUSrc=0.
- mul (R2): RegDst=1, RegWrite=1, ALUCtrl=101.
- div: ALUCtrl=110, NoDest=1, RegWrite=0. The divider writes HI/LO internally.
- mfhi: ALUCtrl=110, RegDst=1, RegWrite=1. The HI unit returns HI when RegWrite=1.
- jr: PCSrc=11, IF_Flush=1, NoDest=1.
- addi: ALUSrc=1, SignExt=1, RegWrite=1, ALUCtrl=000.
- ori: ALUSrc=1, SignExt=0, RegWrite=1, ALUCtrl=010.
- lui: ALUSrc=1, RegWrite=1, ALUCtrl=111.
- lw: ALUSrc=1, SignExt=1, MemRead=1, MemtoReg=1, RegWrite=1, ALUCtrl=000.
- sw: ALUSrc=1, SignExt=1, MemWrite=1, NoDest=1, ALUCtrl=000.
- beq/bne: Branch=1, SignExt=1, NoDest=1, ALUCtrl=001.
  - Taken condition: beq taken iff Cmp_RsRt=1; bne taken iff Cmp_RsRt=0.
  - Taken: PCSrc=01 and IF_Flush=1. Not taken: PCSrc=00 and IF_Flush=0.
- j: PCSrc=10, IF_Flush=1, NoDest=1.
- jal: PCSrc=10, IF_Flush=1, RegWrite=1. The datapath supplies the link value (PC+8) and register $31.
- Illegal instruction (any unlisted opcode, or unlisted funct under R/R2):
  - All outputs at the NOP set, with NoDest=1 and IllegalInstr=1.
  - No side effects: PCSrc=00, RegWrite=0, MemWrite=0.
- Timing:
  - All decode outputs and IllegalInstr are combinational from Opcode/Funct/Cmp_RsRt, zero latency.
  - Decode outputs are not gated by Reset.
- IllegalSeen:
  - Updates only at posedge Clock.
  - Reset=1 at the edge: IllegalSeen<=0. Reset has priority over a simultaneous illegal instruction.
  - Otherwise IllegalSeen <= IllegalSeen | IllegalInstr.
  - Reset value: 0.
- Cmp_RsRt affects only beq/bne outputs.

Test Plan:
1. Cmp=0; R/Add, Sub, Slt, Sll; R2/Mul → RegDst=1, RegWrite=1, ALUSrc=0, PCSrc=00, ALUCtrl=000/001/011/100/101, all memory controls 0.
2. R/Div, R/Mfhi, R/Jr:
   - Div → ALUCtrl=110, NoDest=1, RegWrite=0.
   - Mfhi → ALUCtrl=110, RegWrite=1.
   - Jr → PCSrc=11, IF_Flush=1, NoDest=1.
3. Addi/Ori/Lui/Lw/Sw:
   - All → ALUSrc=1.
   - SignExt = 1/0/0/1/1.
   - Lw → MemRead=1, MemtoReg=1, RegWrite=1.
   - Sw → MemWrite=1, NoDest=1, RegWrite=0.
4. Branch matrix, all with Branch=1:
   - Beq Cmp=0 → PCSrc=00, Flush=0.
   - Beq Cmp=1 → PCSrc=01, Flush=1.
   - Bne Cmp=0 → PCSrc=01, Flush=1.
   - Bne Cmp=1 → PCSrc=00, Flush=0.
5. J → PCSrc=10, Flush=1, RegWrite=0. Jal → PCSrc=10, Flush=1, RegWrite=1.
6. Illegal handling:
   - Opcode=111111 Funct=000000 → NOP outputs, NoDest=1, IllegalInstr=1.
   - Opcode=000000 Funct=111111 → same.
   - Sticky flag: IllegalSeen rises after the next Clock edge and holds for a following valid instruction.
   - Reset=1 for one edge → IllegalSeen=0. Reset=1 with an illegal instruction present → IllegalSeen=0.
